// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - perceptron trainer state encoding, fixed-point constants and word-width helper
package perceptron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    PRED,
    UPDATE,
    DONE
  } state_t;

  // Reference format is Q15.16 in a 32-bit word; other formats rescale ONE.
  localparam int unsigned DEF_Q_N = 16;
  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] ZERO    = 32'h0000_0000;

  function automatic int unsigned fxp_width(input int unsigned sign,
                                            input int unsigned qm,
                                            input int unsigned qn);
    return sign + qm + qn;
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - signed WxW fixed-point multiply: full product, arithmetic shift by Q_N, truncate to W
module fxp_mul #(
  parameter int unsigned W   = 32,
  parameter int unsigned Q_N = 16
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W-1:0] p_o
);

  logic signed [2*W-1:0] full;

  always_comb begin
    full = (2*W)'(a_i) * (2*W)'(b_i);
    p_o  = W'(full >>> Q_N);
  end

endmodule

// File: rtl/neuron_trainer_n.sv
// rtl/neuron_trainer_n.sv - single-neuron perceptron trainer with one shared fixed-point multiplier
// Define SATURATE_EN to clamp accumulator and weight additions instead of wrapping.
module neuron_trainer_n
  import perceptron_pkg::*;
#(
  parameter int unsigned                  N_INPUTS         = 2,
  parameter int unsigned                  SIGN             = 1,
  parameter int unsigned                  Q_M              = 15,
  parameter int unsigned                  Q_N              = 16,
  parameter logic [SIGN+Q_M+Q_N-1:0]      LEARNING_RATE    = 32'h0001_0000,
  parameter logic [SIGN+Q_M+Q_N-1:0]      INIT_WEIGHT      = 32'h0001_0000,
  parameter int unsigned                  TRAIN_ITERATIONS = 10
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [N_INPUTS*(SIGN+Q_M+Q_N)-1:0]         x_i,
  input  logic [SIGN+Q_M+Q_N-1:0]                    target_i,
  input  logic                                       valid_i,
  output logic                                       ready_o,
  output logic [(N_INPUTS+1)*(SIGN+Q_M+Q_N)-1:0]     weights_o,
  output logic [SIGN+Q_M+Q_N-1:0]                    pred_o,
  output logic [SIGN+Q_M+Q_N-1:0]                    err_o,
  output logic [15:0]                                iter_o,
  output logic                                       done_o
);

  localparam int unsigned W  = fxp_width(SIGN, Q_M, Q_N);
  localparam int unsigned NW = N_INPUTS + 1;
  localparam int unsigned IW = $clog2(NW);

  localparam logic [W-1:0] ONE_W  = (Q_N == DEF_Q_N) ? W'(ONE) : (W'(1) << Q_N);
  localparam logic [W-1:0] ZERO_W = W'(ZERO);
  localparam logic [W-1:0] MAX_W  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_W  = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] add_w(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SATURATE_EN
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return s[W] ? MIN_W : MAX_W;
    return s[W-1:0];
`else
    return a + b;
`endif
  endfunction

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NW*W-1:0]      w_q, w_d;
  logic [N_INPUTS*W-1:0] x_q, x_d;
  logic [W-1:0]         target_q, target_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [W-1:0]         scale_q, scale_d;
  logic [W-1:0]         pred_q, pred_d;
  logic [W-1:0]         err_q, err_d;
  logic [15:0]          iter_q, iter_d;

  logic [W-1:0] mul_a, mul_b, mul_p, opnd;
  logic         last_idx;

  fxp_mul #(.W(W), .Q_N(Q_N)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    w_d      = w_q;
    x_d      = x_q;
    target_d = target_q;
    acc_d    = acc_q;
    scale_d  = scale_q;
    pred_d   = pred_q;
    err_d    = err_q;
    iter_d   = iter_q;
    mul_a    = ZERO_W;
    mul_b    = ZERO_W;
    // The top slot is the bias, whose input is the constant 1.0.
    last_idx = (idx_q == IW'(N_INPUTS));
    opnd     = last_idx ? ONE_W : x_q[idx_q*W +: W];

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          x_d      = x_i;
          target_d = target_i;
          acc_d    = ZERO_W;
          idx_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        mul_a = w_q[idx_q*W +: W];
        mul_b = opnd;
        acc_d = add_w(acc_q, mul_p);
        if (last_idx) begin
          idx_d   = '0;
          state_d = PRED;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      PRED: begin
        pred_d  = acc_q[W-1] ? ZERO_W : ONE_W;
        err_d   = target_q - pred_d;
        // Pre-scale the error once so each UPDATE cycle needs a single multiply.
        mul_a   = LEARNING_RATE;
        mul_b   = err_d;
        scale_d = mul_p;
        state_d = UPDATE;
      end
      UPDATE: begin
        mul_a = scale_q;
        mul_b = opnd;
        w_d[idx_q*W +: W] = add_w(w_q[idx_q*W +: W], mul_p);
        if (last_idx) begin
          idx_d   = '0;
          iter_d  = iter_q + 16'd1;
          state_d = (iter_d == 16'(TRAIN_ITERATIONS)) ? DONE : IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      w_q      <= {NW{INIT_WEIGHT}};
      x_q      <= '0;
      target_q <= '0;
      acc_q    <= '0;
      scale_q  <= '0;
      pred_q   <= '0;
      err_q    <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      w_q      <= w_d;
      x_q      <= x_d;
      target_q <= target_d;
      acc_q    <= acc_d;
      scale_q  <= scale_d;
      pred_q   <= pred_d;
      err_q    <= err_d;
      iter_q   <= iter_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign done_o    = (state_q == DONE);
  assign weights_o = w_q;
  assign pred_o    = pred_q;
  assign err_o     = err_q;
  assign iter_o    = iter_q;

endmodule

// File: tb/tb_neuron_trainer_n.sv
// tb/tb_neuron_trainer_n.sv - directed self-checking bench for neuron_trainer_n (default and near-overflow instances)
module tb_neuron_trainer_n;

  localparam int W = 32;
  localparam logic [31:0] ONE  = 32'h0001_0000;
  localparam logic [31:0] NEG1 = 32'hFFFF_0000;
  localparam logic [31:0] BIG  = 32'h7FFF_0000;
`ifdef SATURATE_EN
  localparam logic [31:0] SAT_BIAS = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_BIAS = 32'h8000_0000;
`endif

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic           reset_i;
  logic [2*W-1:0] x_i, x2_i;
  logic [W-1:0]   target_i, target2_i;
  logic           valid_i, valid2_i;
  logic           ready_o, ready2_o;
  logic [3*W-1:0] weights_o, weights2_o;
  logic [W-1:0]   pred_o, pred2_o, err_o, err2_o;
  logic [15:0]    iter_o, iter2_o;
  logic           done_o, done2_o;

  int n_tests = 0;
  int n_fail  = 0;

  neuron_trainer_n dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .x_i       (x_i),
    .target_i  (target_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .weights_o (weights_o),
    .pred_o    (pred_o),
    .err_o     (err_o),
    .iter_o    (iter_o),
    .done_o    (done_o)
  );

  neuron_trainer_n #(.INIT_WEIGHT(32'h7FFF_0000)) dut_big (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .x_i       (x2_i),
    .target_i  (target2_i),
    .valid_i   (valid2_i),
    .ready_o   (ready2_o),
    .weights_o (weights2_o),
    .pred_o    (pred2_o),
    .err_o     (err2_o),
    .iter_o    (iter2_o),
    .done_o    (done2_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
    int guard;
    x_i      = {b, a};
    target_i = t;
    valid_i  = 1'b1;
    guard    = 0;
    while (!ready_o && guard < 50) begin
      tick();
      guard++;
    end
    chk("send_ready", ready_o, 1'b1);
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    int accepts;
    int low_run;
    bit seen_high;

    reset_i   = 1'b1;
    valid_i   = 1'b0;
    valid2_i  = 1'b0;
    x_i       = '0;
    x2_i      = '0;
    target_i  = '0;
    target2_i = '0;

    #12;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_weights", weights_o, {ONE, ONE, ONE});
    chk("rst_pred", pred_o, 32'h0);
    chk("rst_err", err_o, 32'h0);
    chk("rst_iter", iter_o, 16'h0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_big_weights", weights2_o, {BIG, BIG, BIG});
    reset_i = 1'b0;
    tick();

    // x=(0,0), target 0: bias alone drives pred 1.0, error -1.0 pulls bias to 0
    send(32'h0, 32'h0, 32'h0);
    chk("busy_after_accept", ready_o, 1'b0);
    repeat (7) tick();
    chk("s1_ready", ready_o, 1'b1);
    chk("s1_pred", pred_o, ONE);
    chk("s1_err", err_o, NEG1);
    chk("s1_weights", weights_o, {32'h0, ONE, ONE});
    chk("s1_iter", iter_o, 16'd1);

    // x=(1,1), target 1: acc 2.0, zero error leaves weights untouched
    send(ONE, ONE, ONE);
    repeat (7) tick();
    chk("s2_pred", pred_o, ONE);
    chk("s2_err", err_o, 32'h0);
    chk("s2_weights", weights_o, {32'h0, ONE, ONE});
    chk("s2_iter", iter_o, 16'd2);

    // Continuous valid, 12 samples offered, only 10 may be taken
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    tick();
    x_i       = '0;
    target_i  = '0;
    accepts   = 0;
    low_run   = 0;
    seen_high = 1'b0;
    for (int c = 0; c < 120; c++) begin
      valid_i = (accepts < 12);
      if (ready_o) begin
        if (seen_high) chk("ready_low_run", low_run, 7);
        seen_high = 1'b1;
        low_run   = 0;
        if (valid_i) accepts++;
      end else begin
        low_run++;
      end
      tick();
    end
    chk("stream_accepts", accepts, 10);
    chk("stream_iter", iter_o, 16'd10);
    chk("stream_done", done_o, 1'b1);
    chk("stream_ready", ready_o, 1'b0);
    chk("stream_weights", weights_o, {NEG1, ONE, ONE});
    chk("stream_pred", pred_o, 32'h0);
    chk("stream_err", err_o, 32'h0);
    valid_i = 1'b0;

    // Reset during the second UPDATE cycle discards the partial update
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
    tick();
    send(ONE, ONE, 32'h0);
    repeat (5) tick();
    chk("mid_update_w0", weights_o[31:0], 32'h0);
    chk("mid_update_ready", ready_o, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("async_rst_weights", weights_o, {ONE, ONE, ONE});
    #1;
    reset_i = 1'b0;
    tick();
    chk("post_rst_weights", weights_o, {ONE, ONE, ONE});
    chk("post_rst_iter", iter_o, 16'h0);
    chk("post_rst_ready", ready_o, 1'b1);

    // Bias pushed past the positive limit: clamps or wraps depending on build
    x2_i      = {NEG1, NEG1};
    target2_i = ONE;
    valid2_i  = 1'b1;
    chk("big_ready", ready2_o, 1'b1);
    tick();
    valid2_i = 1'b0;
    repeat (7) tick();
    chk("big_pred", pred2_o, 32'h0);
    chk("big_err", err2_o, ONE);
    chk("big_weights", weights2_o, {SAT_BIAS, 32'h7FFE_0000, 32'h7FFE_0000});
    chk("big_iter", iter2_o, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_trainer_n.md
NEURON_TRAINER_N -- requirements
Module: neuron_trainer_n

Interface
REQ-001 SHALL have parameter N_INPUTS, default 2; number of feature inputs (1..16).
REQ-002 SHALL have parameter SIGN, default 1; sign bits in the fixed-point word.
REQ-003 SHALL have parameter Q_M, default 15; integer bits.
REQ-004 SHALL have parameter Q_N, default 16; fraction bits. Word width W = SIGN+Q_M+Q_N.
REQ-005 SHALL have parameter LEARNING_RATE, default 32'h0001_0000 (1.0); update scale.
REQ-006 SHALL have parameter INIT_WEIGHT, default 32'h0001_0000 (1.0); reset value of every weight and the bias.
REQ-007 SHALL have parameter TRAIN_ITERATIONS, default 10; number of samples consumed before done.
REQ-008 SHALL have port clk_i, input, 1, clock; reset reset_i, asynchronous, active-high; clock clk_i.
REQ-009 SHALL have port reset_i, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port x_i, input, N_INPUTS*W, packed samples; x_k = x_i[k*W +: W].
REQ-011 SHALL have port target_i, input, W, expected output (0.0 or 1.0).
REQ-012 SHALL have port valid_i, input, 1, sample valid.
REQ-013 SHALL have port ready_o, output, 1, trainer can accept a sample.
REQ-014 SHALL have port weights_o, output, (N_INPUTS+1)*W, weights w_0..w_{N-1}, bias in the top slot.
REQ-015 SHALL have port pred_o, output, W, last prediction.
REQ-016 SHALL have port err_o, output, W, last error.
REQ-017 SHALL have port iter_o, output, 16, samples consumed.
REQ-018 SHALL have port done_o, output, 1, training complete.

Function
REQ-019 SHALL implement the FSM IDLE -> MAC -> PRED -> UPDATE -> IDLE|DONE.
REQ-020 ready_o SHALL be 1 only in IDLE; a sample SHALL be accepted on a clock edge with valid_i&ready_o, latching x_i and target_i.
REQ-021 MAC SHALL last N_INPUTS+1 cycles, one multiply per cycle, accumulating acc = sum(w_k*x_k) + bias*1.0.
REQ-022 Each product SHALL be full 2W signed, arithmetic-shifted right by Q_N, then truncated to W before accumulation.
REQ-023 PRED (1 cycle) SHALL set pred_o = 1.0 if acc >= 0, else 0.0, and err_o = target - pred_o.
REQ-024 UPDATE SHALL last N_INPUTS+1 cycles, applying w_k += ((LEARNING_RATE*err)>>>Q_N)*x_k>>>Q_N, with x = 1.0 for the bias.
REQ-025 err_o = 0 SHALL leave all weights bit-identical.
REQ-026 After UPDATE, iter_o SHALL increment; if it equals TRAIN_ITERATIONS the FSM SHALL go to DONE, else to IDLE.
REQ-027 ready_o SHALL be low for exactly 2*N_INPUTS+3 cycles after each acceptance.
REQ-028 valid_i asserted outside IDLE SHALL be ignored; no queuing.
REQ-029 DONE SHALL be terminal until reset: done_o=1, ready_o=0, weights held.
REQ-030 weights_o SHALL change only during UPDATE.

Reset
REQ-031 Reset SHALL set: state IDLE, ready_o=1, every weight = INIT_WEIGHT, pred_o=0, err_o=0, iter_o=0, done_o=0.
REQ-032 Reset asserted mid-MAC or mid-UPDATE SHALL abort immediately; partial updates are discarded via re-initialisation.

Configuration
REQ-033 With SATURATE_EN defined, the accumulator and weight additions SHALL clamp to the signed max/min of W.
REQ-034 Without SATURATE_EN, the accumulator and weight additions SHALL wrap modulo 2^W.

Structure
REQ-035 Package perceptron_pkg SHALL hold state_t (IDLE, MAC, PRED, UPDATE, DONE), the fixed-point constants ONE and ZERO, and the width function.
REQ-036 A sub-module fxp_mul (signed W x W, shift by Q_N, truncate to W) SHALL be instantiated once and shared between MAC and UPDATE.

Verification
REQ-037 Defaults, x=(0,0), target 0 -> pred 1.0, err -1.0 (0xFFFF_0000), bias becomes 0, w0=w1=1.0.
REQ-038 Then x=(1.0,1.0), target 1.0 -> acc 2.0, pred 1.0, err 0, weights unchanged.
REQ-039 Hold valid_i high continuously -> exactly one acceptance per 2N+4 cycles; ready_o low for 7 cycles (N=2).
REQ-040 TRAIN_ITERATIONS=10, stream 12 samples -> iter_o=10, done_o=1, ready_o=0, last 2 samples never accepted.
REQ-041 Weight 0x7FFF_0000, x=1.0, err +1.0 -> result 0x7FFF_FFFF with SATURATE_EN, 0x8000_0000 without.
REQ-042 Assert reset_i during the 2nd UPDATE cycle -> next cycle all weights INIT_WEIGHT, iter_o 0, ready_o 1.
